// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types plus the hazard unit's state enum,
// control bundle and instruction-field helpers.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // Primary opcodes of the MIPS subset this datapath executes.
    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0A,
        SLTIU = 6'h0B,
        ANDI  = 6'h0C,
        ORI   = 6'h0D,
        XORI  = 6'h0E,
        LUI   = 6'h0F,
        LW    = 6'h23,
        SW    = 6'h2B
    } opcode_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hazard_state_t;

    // Per-cycle pipeline controls; bit order is PC first, then the stages.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_FREEZE = '0;
    localparam hazard_ctrl_t CTRL_ADVANCE = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                              exmem_en: 1'b1, memwb_en: 1'b1,
                                              ifid_flush: 1'b0, idex_flush: 1'b0,
                                              exmem_flush: 1'b0};

    function automatic regbits_t instr_rs(input word_t instr);
        return instr[25:21];
    endfunction

    function automatic regbits_t instr_rt(input word_t instr);
        return instr[20:16];
    endfunction

    // True when the instruction reads rt as a source operand (not a destination).
    function automatic logic uses_rt(input word_t instr);
        opcode_t op;
        logic    result;
        op = opcode_t'(instr[31:26]);
        case (op)
            RTYPE, BEQ, BNE, SW: result = 1'b1;
            default:             result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: bundle between the datapath and the hazard unit.
// The hu modport is the hazard unit's view; dp is the datapath's view.
interface hazard_unit_if;
    import cpu_types_pkg::*;

    logic     ihit;
    logic     dhit;
    word_t    ifid_instr;
    logic     idex_dREN;
    regbits_t idex_rt;
    logic     exmem_dREN;
    logic     exmem_dWEN;
    logic     exmem_pcsrc;
    logic     memwb_halt;
    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     dwait;
    logic     halt;

    modport hu (
        input  ihit, dhit, ifid_instr, idex_dREN, idex_rt,
               exmem_dREN, exmem_dWEN, exmem_pcsrc, memwb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, dwait, halt
    );

    modport dp (
        output ihit, dhit, ifid_instr, idex_dREN, idex_rt,
               exmem_dREN, exmem_dWEN, exmem_pcsrc, memwb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, dwait, halt
    );

endinterface

// File: rtl/hazard_stats.sv
// hazard_stats: three free-running wrap-around event counters
// (load-use stalls, redirect flushes, DWAIT cycles) that hold still in HALT.
module hazard_stats
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  lu_stall,
    input  logic  flush,
    input  logic  in_dwait,
    input  logic  frozen,
    output word_t lu_stall_cnt,
    output word_t flush_cnt,
    output word_t dwait_cnt
);

    logic [2:0] inc;

    assign inc = {in_dwait, flush, lu_stall};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            word_t cnt_reg;

            // Count qualifying cycles; the adder wraps naturally at 2^32.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    cnt_reg <= '0;
                end else if (!frozen && inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign lu_stall_cnt = g_cnt[0].cnt_reg;
    assign flush_cnt    = g_cnt[1].cnt_reg;
    assign dwait_cnt    = g_cnt[2].cnt_reg;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/enable control for the five-stage pipeline.
// Handles load-use bubbles, MEM-resolved redirects, data-memory waits and
// halt. Optional event counters are built when HAZARD_STATS_EN is defined.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  word_t    ifid_instr,
    input  logic     idex_dREN,
    input  regbits_t idex_rt,
    input  logic     exmem_dREN,
    input  logic     exmem_dWEN,
    input  logic     exmem_pcsrc,
    input  logic     memwb_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     idex_en,
    output logic     exmem_en,
    output logic     memwb_en,
    output logic     ifid_flush,
    output logic     idex_flush,
    output logic     exmem_flush,
    output logic     dwait,
    output logic     halt
`ifdef HAZARD_STATS_EN
    ,
    output word_t    lu_stall_cnt,
    output word_t    flush_cnt,
    output word_t    dwait_cnt
`endif
);

    hazard_state_t state_reg;
    hazard_state_t state_next;
    logic          ihit_held_reg;
    logic          ihit_eff;
    logic          memreq;
    logic          load_use;
    logic          rule_flush;
    logic          rule_lu;
    hazard_ctrl_t  ctrl;

    // Only opcode, rs and rt take part in hazard detection.
    logic unused_instr_low;
    assign unused_instr_low = ^ifid_instr[15:0];

    assign ihit_eff = ihit | ihit_held_reg;
    assign memreq   = exmem_dREN | exmem_dWEN;

    // A load into $0 never creates a real dependence.
    assign load_use = idex_dREN && (idex_rt != '0) &&
                      ((idex_rt == instr_rs(ifid_instr)) ||
                       (uses_rt(ifid_instr) && (idex_rt == instr_rt(ifid_instr))));

    // Priority-resolved controls and next state; HALT and reset freeze everything.
    always_comb begin
        ctrl       = CTRL_FREEZE;
        state_next = state_reg;
        rule_flush = 1'b0;
        rule_lu    = 1'b0;
        if (!nRST) begin
            state_next = RUN;
        end else begin
            case (state_reg)
                RUN, DWAIT: begin
                    if (memwb_halt) begin
                        state_next = HALT;
                    end else if (memreq && !dhit) begin
                        state_next = DWAIT;
                    end else begin
                        state_next = RUN;
                        if (exmem_pcsrc) begin
                            // Redirect does not need a fetch; younger stages are squashed.
                            ctrl             = CTRL_ADVANCE;
                            ctrl.ifid_flush  = 1'b1;
                            ctrl.idex_flush  = 1'b1;
                            ctrl.exmem_flush = 1'b1;
                            rule_flush       = 1'b1;
                        end else if (load_use) begin
                            ctrl            = CTRL_ADVANCE;
                            ctrl.pc_en      = 1'b0;
                            ctrl.ifid_en    = 1'b0;
                            ctrl.idex_flush = 1'b1;
                            rule_lu         = 1'b1;
                        end else if (!ihit_eff) begin
                            ctrl            = CTRL_ADVANCE;
                            ctrl.pc_en      = 1'b0;
                            ctrl.ifid_flush = 1'b1;
                        end else begin
                            ctrl = CTRL_ADVANCE;
                        end
                    end
                end
                default: begin
                    state_next = HALT;
                end
            endcase
        end
    end

    // State register plus the fetch-complete latch kept across a data wait.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg     <= RUN;
            ihit_held_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (ctrl.pc_en || ctrl.ifid_flush) begin
                ihit_held_reg <= 1'b0;
            end else if ((state_reg == DWAIT) && ihit) begin
                ihit_held_reg <= 1'b1;
            end
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;

    // Status flags read as 0 for as long as reset is held.
    assign dwait = nRST && (state_reg == DWAIT);
    assign halt  = nRST && (state_reg == HALT);

`ifdef HAZARD_STATS_EN
    hazard_stats u_stats (
        .CLK          (CLK),
        .nRST         (nRST),
        .lu_stall     (rule_lu),
        .flush        (rule_flush),
        .in_dwait     (state_reg == DWAIT),
        .frozen       (state_reg == HALT),
        .lu_stall_cnt (lu_stall_cnt),
        .flush_cnt    (flush_cnt),
        .dwait_cnt    (dwait_cnt)
    );
`else
    logic unused_rule_flags;
    assign unused_rule_flags = rule_flush ^ rule_lu;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the five-stage MIPS datapath that complements the forwarding unit. Forwarding resolves register dependences without stalling; this block handles everything forwarding cannot: load-use stalls, branch/jump flushes resolved in MEM, data-memory waits and halt. It drives the enable and flush controls of the PC and all four pipeline registers every cycle. It tracks memory-wait and halt state sequentially.

## Interface
Parameters:
- none; widths come from `cpu_types_pkg`: `word_t` is 32 bits and `regbits_t` is 5 bits.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge
- `nRST`  in  1  synchronous, active-low reset
- `ihit`  in  1  instruction fetch complete this cycle
- `dhit`  in  1  data access complete this cycle
- `ifid_instr`  in  32  instruction in IF/ID
- `idex_dREN`  in  1  instruction in ID/EX is a load
- `idex_rt`  in  5  load destination in ID/EX
- `exmem_dREN`, `exmem_dWEN`  in  1 each  memory access pending in MEM
- `exmem_pcsrc`  in  1  taken branch/jump resolved in MEM
- `memwb_halt`  in  1  halt instruction in MEM/WB
- `pc_en`  out  1  PC loads next value
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register advance
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1 each  register loads NOP; flush wins over enable
- `dwait`  out  1  state is DWAIT
- `halt`  out  1  state is HALT

## Operation
- States: RUN, DWAIT, HALT. Registers: `state`, `ihit_held`. `ihit_eff = ihit | ihit_held`.
- `memreq = exmem_dREN | exmem_dWEN`.
- Load-use: `idex_dREN && idex_rt != 0 && (idex_rt == ifid.rs || (uses_rt(ifid) && idex_rt == ifid.rt))`.
  - `uses_rt` is true for R-type, BEQ, BNE and SW.
- Outputs in RUN and DWAIT are resolved in strict priority order:
  1. `memwb_halt`: all enables 0, all flushes 0; next state HALT.
  2. `memreq && !dhit`: all enables 0, all flushes 0; next state DWAIT.
  3. `exmem_pcsrc`: all enables 1; `ifid_flush`, `idex_flush` and `exmem_flush` are 1. The redirect happens regardless of `ihit_eff`.
  4. Load-use: `pc_en=0`, `ifid_en=0`, `idex_flush=1`; `exmem_en` and `memwb_en` are 1.
  5. `!ihit_eff`: `pc_en=0`, `ifid_flush=1`; the downstream enables are 1.
  6. Otherwise: all enables 1, all flushes 0.
- DWAIT:
  - Rule 2 holds until `dhit` is seen.
  - In the cycle `dhit=1`, the outputs follow rules 3–6 and the next state is RUN.
  - Any `ihit` pulse seen while in DWAIT sets `ihit_held`. The arbiter gives priority to the d-side, so the fetch result must not be lost.
- `ihit_held` clears on any edge where `pc_en=1` or `ifid_flush=1`.
- HALT: all enables and flushes are 0; the block stays in HALT until `nRST`.

## Timing
- Stall, flush and enable outputs are combinational from the inputs and current state; there is zero latency to the pipeline-register edges.
- `dwait` and `halt` are decoded from registered state. They assert the cycle after the triggering event.
- Reset, on an edge with `nRST=0`:
  - state goes to RUN and `ihit_held` goes to 0.
  - While `nRST` is low, all enables are 0 and all flushes are 0; `dwait=0`, `halt=0`.
- Reset in the middle of DWAIT or HALT overrides everything.
- Load-use stalls last exactly 1 cycle: after the bubble, `idex_dREN` becomes 0.
- Simultaneous `exmem_pcsrc` and load-use: rule 3 wins. The dependent instruction is flushed, so no stall occurs.
- `dhit` together with `memwb_halt`: halt wins.

## Configuration
- `HAZARD_STATS_EN` defined:
  - Adds three 32-bit outputs: `lu_stall_cnt` (cycles where rule 4 applies), `flush_cnt` (cycles where rule 3 applies) and `dwait_cnt` (cycles with `state==DWAIT`).
  - Counters wrap at 2^32, reset to 0 on `nRST`, and freeze in HALT.
- Not defined: the ports and the logic are absent, and the block behaves identically otherwise.

## Structure
- `cpu_types_pkg`:
  - `hazard_state_t` enum {RUN, DWAIT, HALT}
  - `uses_rt(word_t)` function; it reuses the existing opcode enum.
- `hazard_unit_if.vh`: interface with a `hu` modport; the datapath takes the other side.
- Sub-module `hazard_stats`: three saturating-free wrap counters, instantiated only under `HAZARD_STATS_EN`.

## Test plan
- ID/EX `lw $2`, IF/ID `add $3,$2,$4`, `ihit=1`:
  - that cycle: `pc_en=0`, `ifid_en=0`, `idex_flush=1`.
  - next cycle (`idex_dREN=0`): all enables are 1.
- ID/EX `lw $0`, IF/ID `add $3,$0,$4`: no stall; all enables 1, no flushes.
- `exmem_pcsrc=1`, `ihit=0`, load-use also true: `pc_en=1`; `ifid_flush`, `idex_flush` and `exmem_flush` are 1.
- `exmem_dREN=1`, `dhit=0` for 3 cycles, with an `ihit` pulse in cycle 2:
  - the 3 cycles: all enables are 0, and `dwait=1` from cycle 2.
  - the `dhit` cycle, with `ihit=0`: `pc_en=1` and `ifid_en=1` (held ihit); then `dwait=0`.
- `memwb_halt=1`: enables are 0 that cycle and thereafter, `halt=1` from the next cycle. Later `ihit`/`dhit` have no effect until `nRST=0`.
- `nRST=0` in the middle of DWAIT with `ihit_held=1`:
  - after the edge: `dwait=0`, `ihit_held=0`, and the counters (if enabled) are 0.
  - the first RUN cycle with `ihit=0` gives `pc_en=0`.
